// File: rtl/fir_mac_sched_if.sv
// fir_mac_sched_if: bundles the sample stream, output stream, coefficient
// config port and external multiplier port of fir_mac_sched.
//   slave  : the filter scheduler's view (sample in, result out, drives mul).
//   master : the surrounding system's view (source, sink, config, multiplier).
interface fir_mac_sched_if #(
  parameter int DATA_W = 32,
  parameter int COEF_W = 7,
  parameter int ADDR_W = 4
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [COEF_W-1:0] cfg_data;
  logic              cfg_drop;
  logic              mul_ce;
  logic [DATA_W-1:0] mul_a;
  logic [COEF_W-1:0] mul_b;
  logic [DATA_W-1:0] mul_p;

  modport slave (
    input  in_data, in_valid, out_ready, cfg_we, cfg_addr, cfg_data, mul_p,
    output in_ready, out_data, out_valid, cfg_drop, mul_ce, mul_a, mul_b
  );

  modport master (
    output in_data, in_valid, out_ready, cfg_we, cfg_addr, cfg_data, mul_p,
    input  in_ready, out_data, out_valid, cfg_drop, mul_ce, mul_a, mul_b
  );
endinterface

// File: rtl/fir_mac_sched.sv
// fir_mac_sched: time-multiplexed FIR filter. Holds the sample delay line and
// coefficient file, issues one tap (x[tap], coef[tap]) per cycle to an external
// pipelined multiplier, accumulates the returned products and presents one
// result per accepted sample.
// Ports:
//   clk    : clock, rising edge.
//   reset  : asynchronous reset, active low.
//   bus    : fir_mac_sched_if.slave -- in_* sample stream, out_* result
//            stream, cfg_* coefficient writes / drop pulse, mul_* multiplier.
module fir_mac_sched #(
  parameter int N_TAPS  = 11,
  parameter int DATA_W  = 32,
  parameter int COEF_W  = 7,
  parameter int MUL_LAT = 1,
  parameter int ADDR_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  fir_mac_sched_if.slave      bus
);

  localparam int DRN_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_e;

  state_e state_q, state_d;

  logic [N_TAPS-1:0][DATA_W-1:0] x_q;
  logic [N_TAPS-1:0][COEF_W-1:0] coef_q;
  logic [ADDR_W-1:0]             tap_q;
  logic [DRN_W-1:0]              drain_q;
  logic [DATA_W-1:0]             acc_q;
  logic [DATA_W-1:0]             out_data_q;
  logic                          out_valid_q;
  logic                          cfg_drop_q;
  logic [MUL_LAT:1]              vld_pipe_q;

  logic              in_ready;
  logic              mul_ce;
  logic              issue;
  logic              accept;
  logic              tap_last;
  logic              drain_last;
  logic              vld_out;
  logic [DATA_W-1:0] acc_sum;
  logic [DATA_W-1:0] a_sel;
  logic [COEF_W-1:0] b_sel;

  assign accept     = bus.in_valid && in_ready;
  assign tap_last   = (tap_q == ADDR_W'(N_TAPS - 1));
  assign drain_last = (drain_q == DRN_W'(MUL_LAT - 1));
  assign vld_out    = vld_pipe_q[MUL_LAT];
  assign acc_sum    = acc_q + bus.mul_p;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept)        state_d = RUN;
      RUN:   if (tap_last)      state_d = DRAIN;
      DRAIN: if (drain_last)    state_d = OUT;
      OUT:   if (bus.out_ready) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // in_ready is gated by reset so it reads 0 while reset is held.
  always_comb begin
    in_ready = 1'b0;
    mul_ce   = 1'b0;
    issue    = 1'b0;
    case (state_q)
      IDLE:  in_ready = reset;
      RUN:   begin mul_ce = 1'b1; issue = 1'b1; end
      DRAIN: mul_ce = 1'b1;
      default: ;
    endcase
  end

  // Operand mux; tap_q can run one past the last tap in DRAIN, where the
  // operands are forced to zero anyway.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      if (tap_q == ADDR_W'(i)) begin
        a_sel = x_q[i];
        b_sel = coef_q[i];
      end
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q         <= '0;
      tap_q       <= '0;
      drain_q     <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      vld_pipe_q  <= '0;
    end else begin
      if (accept) begin
        x_q     <= {x_q[N_TAPS-2:0], bus.in_data};
        tap_q   <= '0;
        drain_q <= '0;
        acc_q   <= '0;
      end

      if (state_q == RUN) tap_q <= tap_q + ADDR_W'(1);

      // Issue-valid tracker advances in lock-step with the multiplier.
      if (mul_ce) begin
        vld_pipe_q[1] <= issue;
        for (int i = 2; i <= MUL_LAT; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
      end

      if (vld_out) acc_q <= acc_sum;

      if (state_q == DRAIN) begin
        drain_q <= drain_last ? '0 : drain_q + DRN_W'(1);
        // The final product lands on this same edge, so fold it in directly.
        if (drain_last) begin
          out_data_q  <= vld_out ? acc_sum : acc_q;
          out_valid_q <= 1'b1;
        end
      end

      if (state_q == OUT && bus.out_ready) out_valid_q <= 1'b0;
    end
  end

  // ---------------- coefficient file ----------------
  // Out-of-range addresses match no entry and are silently ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coef_q     <= '0;
      cfg_drop_q <= 1'b0;
    end else begin
      cfg_drop_q <= bus.cfg_we && (state_q != IDLE);
      if (bus.cfg_we && state_q == IDLE) begin
        for (int i = 0; i < N_TAPS; i++) begin
          if (bus.cfg_addr == ADDR_W'(i)) coef_q[i] <= bus.cfg_data;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cfg_drop  = cfg_drop_q;
  assign bus.mul_ce    = mul_ce;
  assign bus.mul_a     = issue ? a_sel : '0;
  assign bus.mul_b     = issue ? b_sel : '0;

endmodule

// File: tb/tb_fir_mac_sched.sv
// tb_fir_mac_sched: scoreboard bench for fir_mac_sched with a behavioural
// 1-cycle multiplier. Expected outputs come from a delay-line/coefficient
// model updated as stimulus is driven.
module tb_fir_mac_sched;
  localparam int NT = 11;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errs;

  fir_mac_sched_if #(.DATA_W(32), .COEF_W(7), .ADDR_W(4)) bus();

  fir_mac_sched #(.N_TAPS(NT), .DATA_W(32), .COEF_W(7), .MUL_LAT(1), .ADDR_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // external multiplier: signed sample x unsigned coef, truncated
  always @(posedge clk) begin
    if (bus.mul_ce)
      bus.mul_p <= 32'(longint'($signed(bus.mul_a)) * longint'({1'b0, bus.mul_b}));
  end

  // reference model + scoreboard
  logic [31:0] mx [NT];
  int          mc [NT];
  logic [31:0] sb [$];
  int          lat_q [$];
  logic        ov_prev;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model_out();
    logic [31:0] acc;
    acc = '0;
    for (int k = 0; k < NT; k++)
      acc += 32'(longint'($signed(mx[k])) * longint'(mc[k]));
    return acc;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NT; k++) begin mx[k] = '0; mc[k] = 0; end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // monitor: latency on out_valid rise, data on handshake
  always @(negedge clk) begin
    if (reset) begin
      if (bus.out_valid && !ov_prev) begin
        if (lat_q.size() != 0) chk("latency", 32'(cyc - lat_q.pop_front()), 32'd12);
        else                   chk("spurious_valid", 32'd1, 32'd0);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() != 0) chk("out_data", bus.out_data, sb.pop_front());
        else                chk("spurious_out", 32'd1, 32'd0);
      end
    end
    ov_prev = bus.out_valid;
  end

  task automatic cfg_write(int a, int d);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 4'(a);
    bus.cfg_data = 7'(d);
    if (a < NT) mc[a] = d;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  // Drive one sample (optionally with a same-edge coefficient write).
  task automatic send(logic [31:0] x, bit we = 1'b0, int a = 0, int d = 0);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    while (!bus.in_ready && n < 100) begin tick(); n++; end
    if (!bus.in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    if (we) begin
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 4'(a);
      bus.cfg_data = 7'(d);
      if (a < NT) mc[a] = d;
    end
    for (int k = NT - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = x;
    sb.push_back(model_out());
    lat_q.push_back(cyc + 1);
    tick();
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin tick(); n++; end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    checks = 0; errs = 0; ov_prev = 1'b0;
    model_clear();
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.mul_p = '0;
    tick(); tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  bus.out_data, 32'd0);
    chk("rst_mul_ce",    32'(bus.mul_ce), 32'd0);
    chk("rst_mul_a",     bus.mul_a, 32'd0);
    chk("rst_cfg_drop",  32'(bus.cfg_drop), 32'd0);
    @(negedge clk) reset = 1'b1;
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // impulse response: 1,2,...,11
    for (int k = 0; k < NT; k++) cfg_write(k, k + 1);
    send(32'd1);
    for (int k = 0; k < 10; k++) send(32'd0);
    wait_done();

    // signed sample x unsigned coefficient
    for (int k = 0; k < NT; k++) cfg_write(k, (k == 0) ? 127 : 0);
    send(-32'sd5);
    wait_done();
    cfg_write(1, 127);
    send(32'd3);
    wait_done();

    // wrap-around, coefficient written on the accept edge
    cfg_write(1, 0);
    send(32'h7FFF_FFFF, 1'b1, 0, 2);
    wait_done();
    cfg_write(0, 64);
    cfg_write(1, 64);
    send(32'h4000_0000);
    send(32'h4000_0000);
    wait_done();

    // backpressure
    bus.out_ready = 1'b0;
    send(32'h0000_1234);
    for (int n = 0; n < 100 && !bus.out_valid; n++) tick();
    chk("bp_valid", 32'(bus.out_valid), 32'd1);
    for (int n = 0; n < 5; n++) begin
      chk("bp_hold_data", bus.out_data, (sb.size() != 0) ? sb[0] : 32'hDEAD_BEEF);
      chk("bp_in_ready",  32'(bus.in_ready), 32'd0);
      chk("bp_mul_ce",    32'(bus.mul_ce), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_release_valid", 32'(bus.out_valid), 32'd0);

    // config while busy is dropped; out-of-range write ignored
    send(32'd5);
    bus.cfg_we = 1'b1; bus.cfg_addr = 4'd0; bus.cfg_data = 7'd9;
    tick();
    bus.cfg_we = 1'b0;
    chk("busy_cfg_drop", 32'(bus.cfg_drop), 32'd1);
    chk("busy_mul_ce",   32'(bus.mul_ce), 32'd1);
    tick();
    chk("busy_drop_pulse", 32'(bus.cfg_drop), 32'd0);
    wait_done();
    cfg_write(12, 5);
    chk("oob_cfg_drop", 32'(bus.cfg_drop), 32'd0);
    send(32'd1);
    wait_done();

    // reset in the middle of a run
    send(32'd9);
    for (int n = 0; n < 5; n++) tick();
    chk("mid_mul_ce_before", 32'(bus.mul_ce), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_mul_ce",    32'(bus.mul_ce), 32'd0);
    chk("mid_rst_in_ready",  32'(bus.in_ready), 32'd0);
    chk("mid_rst_mul_a",     bus.mul_a, 32'd0);
    sb.delete();
    lat_q.delete();
    model_clear();
    tick(); tick();
    @(negedge clk) reset = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    send(32'd77);
    wait_done();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fir_mac_sched.md
Name: fir_mac_sched

Overview:
- Time-multiplexes one pipelined multiplier (signed 32-bit sample × unsigned 7-bit coefficient, 32-bit truncated product, MUL_LAT cycles when mul_ce is high) across all FIR taps.
- Holds the sample delay line and the coefficient register file.
- Issues one tap product per cycle, accumulates the products, and returns one filtered output per accepted input sample over valid/ready handshakes.
- Sits between the sample stream source and the downstream consumer. The multiplier instance is external and driven through the mul_* ports.

Parameters:
- N_TAPS, 11, number of filter taps (≥2).
- DATA_W, 32, sample, product and accumulator width.
- COEF_W, 7, unsigned coefficient width.
- MUL_LAT, 1, multiplier latency in mul_ce-enabled cycles (≥1).
- ADDR_W, 4, coefficient address width; requires 2^ADDR_W ≥ N_TAPS.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_data  in  DATA_W  signed input sample.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a sample.
- out_data  out  DATA_W  signed filter output.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- cfg_we  in  1  coefficient write strobe.
- cfg_addr  in  ADDR_W  tap index to write.
- cfg_data  in  COEF_W  coefficient value.
- cfg_drop  out  1  one-cycle pulse: a write was rejected because the block was busy.
- mul_ce  out  1  multiplier clock enable.
- mul_a  out  DATA_W  multiplier operand 0, the sample.
- mul_b  out  COEF_W  multiplier operand 1, the coefficient.
- mul_p  in  DATA_W  multiplier product.

Behaviour:
- Reset (asynchronous, while reset=0), all registered outputs and state are cleared:
  - state=IDLE.
  - Delay line and coefficient file all 0; acc=0; tap counter=0.
  - out_valid=0, out_data=0, cfg_drop=0, mul_ce=0, mul_a=0, mul_b=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - Reset mid-operation abandons the computation; no partial output is ever presented.
- States: IDLE, RUN, DRAIN, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready (accept edge E0): delay line shifts (x[k]←x[k-1], x[0]←in_data), acc←0, tap←0, go to RUN.
- RUN, tap=0..N_TAPS-1:
  - mul_ce=1, mul_a=x[tap], mul_b=coef[tap]; tap increments each cycle.
  - On the cycle with tap=N_TAPS-1, go to DRAIN.
  - A MUL_LAT-deep valid shift register, clocked only when mul_ce=1, tracks issued taps.
  - acc←acc+mul_p on every edge where the delayed valid is 1.
- DRAIN:
  - mul_ce=1, operands are don't-care, issue-valid=0.
  - Lasts MUL_LAT cycles, until the last product has been accumulated.
  - Then out_data←final acc, out_valid←1, go to OUT.
- OUT:
  - mul_ce=0. out_valid=1; out_data is held stable until out_valid&out_ready.
  - On that handshake edge: out_valid←0, go to IDLE. Earliest next accept is the following cycle; no bypass.
- Latency: out_valid rises at edge E(N_TAPS+MUL_LAT) after accept edge E0 (E12 with defaults).
  - Minimum throughput is one sample per N_TAPS+MUL_LAT+2 cycles.
- in_ready=0 in RUN, DRAIN and OUT. in_data is ignored when in_ready=0.
- Arithmetic:
  - The product is DATA_W as delivered by the multiplier.
  - acc is DATA_W two's complement, wrapping modulo 2^DATA_W with no saturation.
  - out_data is identical to acc.
- Coefficient writes:
  - Accepted only in IDLE: coef[cfg_addr]←cfg_data on the edge.
  - cfg_addr ≥ N_TAPS: write ignored, no cfg_drop.
  - cfg_we in RUN/DRAIN/OUT: write discarded, cfg_drop=1 for the next cycle.
  - A write and a sample accept on the same IDLE edge: both take effect. The new coefficient is used for that sample's computation.
- The delay line is updated only on accept edges. Tap order is fixed (tap 0 = newest sample).

Test Plan:
- Impulse response: write coef[k]=k+1 (k=0..10); send 1 then ten 0s with out_ready=1 → out_data sequence 1,2,…,11. Each out_valid rises exactly 12 cycles after its accept edge.
- Signed/unsigned: all coefs 0 except coef[0]=127; send in_data=-5 → out_data=-635 (0xFFFFFD85). Then send 3 with coef[1]=127 written → out_data=381+(-635)=-254.
- Wrap: coef[0]=2, others 0; send 0x7FFFFFFF → out_data=0xFFFFFFFE. With coef[0]=coef[1]=64, send 0x40000000 twice → second out_data=0x00000000 (mod 2^32).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_data stable, in_ready=0, mul_ce=0; release → handshake, in_ready=1 next cycle.
- Config while busy: pulse cfg_we (addr 0, data 9) during RUN → cfg_drop=1 for one cycle, coef[0] unchanged (verified by impulse). Write to addr 12 in IDLE → ignored, cfg_drop=0.
- Reset mid-run: assert reset=0 at tap 5 → out_valid, mul_ce, in_ready drop to reset values asynchronously. After release: in_ready=1, coefs and delay line 0, and the next sample yields out_data=0.
